// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame geometry, common command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StSend,
        StAck,
        StWaitIdle
    } ps2_state_e;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned FALLS_TO_STOP = 10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Processor-side request/status bundle for the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       tx_nack;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_error, tx_nack
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_error, tx_nack
    );
endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-FF synchronizers and a falling-edge strobe on the clock line.
// With PS2_TX_FILTER_EN defined the clock also passes a FILTER_LEN-sample deglitcher.
module ps2_line_sync #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_level_o,
    output logic data_level_o,
    output logic clk_fall_o
);
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_lvl;
    logic       clk_prev_q;

    // Reset to the idle-high bus level so leaving reset never fakes a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

`ifdef PS2_TX_FILTER_EN
    localparam int unsigned       FiltW    = $clog2(FILTER_LEN) + 1;
    localparam logic [FiltW-1:0]  FiltLast = FiltW'(FILTER_LEN - 1);

    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             filt_q, filt_d;

    always_comb begin
        filt_cnt_d = '0;
        filt_d     = filt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign clk_lvl = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign clk_lvl = clk_sync_q[1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl;
        end
    end

    assign clk_fall_o   = clk_prev_q & ~clk_lvl;
    assign clk_level_o  = clk_lvl;
    assign data_level_o = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, device ack and timeout.
// Build with PS2_TX_FILTER_EN to deglitch the PS/2 clock before edge detection.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int unsigned      InhW     = $clog2(INHIBIT_CYCLES) + 1;
    localparam int unsigned      ToW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [InhW-1:0]  InhLast  = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]   ToLimit  = ToW'(TIMEOUT_CYCLES);
    localparam logic [3:0]       StopFall = 4'(FALLS_TO_STOP - 1);

    ps2_state_e         state_q, state_d;
    logic [InhW-1:0]    inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]     to_cnt_q, to_cnt_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [DATA_BITS:0] frame_q, frame_d;
    logic               data_oe_q, data_oe_d;
    logic               nack_q, nack_d;

    logic clk_lvl, data_lvl, clk_fall;
    logic done_evt, err_evt, nack_evt;
    logic ack_sample, to_run;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clock        (clock),
        .reset        (reset),
        .ps2_clk_i    (ps2_clk_in),
        .ps2_data_i   (ps2_data_in),
        .clk_level_o  (clk_lvl),
        .data_level_o (data_lvl),
        .clk_fall_o   (clk_fall)
    );

    assign ack_sample = (state_q == StAck) && clk_fall;
    assign to_run     = state_q inside {StSend, StAck, StWaitIdle};

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        nack_d    = nack_q;
        done_evt  = 1'b0;
        err_evt   = 1'b0;
        nack_evt  = 1'b0;

        unique case (state_q)
            StIdle: begin
                data_oe_d = 1'b0;
                if (tx.tx_valid) begin
                    frame_d   = {odd_parity(tx.tx_data), tx.tx_data};
                    bitcnt_d  = '0;
                    nack_d    = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = StSend;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StSend: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (clk_fall) begin
                    if (bitcnt_q == StopFall) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end else begin
                        // Open-drain: pulling low sends a 0.
                        data_oe_d = ~frame_q[0];
                        frame_d   = frame_q >> 1;
                        bitcnt_d  = bitcnt_q + 4'd1;
                    end
                end
            end
            StAck: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (clk_fall) begin
                    if (!data_lvl) begin
                        state_d = StWaitIdle;
                    end else begin
                        err_evt  = 1'b1;
                        nack_evt = 1'b1;
                        nack_d   = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (clk_lvl && data_lvl) begin
                    done_evt = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A real ack/nack decision on the same cycle takes precedence over the timeout.
        if (to_run && (to_cnt_q >= ToLimit) && !ack_sample && !done_evt) begin
            err_evt   = 1'b1;
            data_oe_d = 1'b0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bitcnt_q  <= '0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bitcnt_q  <= bitcnt_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
            nack_q    <= nack_d;
        end
    end

    assign ps2_clk_oe  = (state_q == StInhibit);
    assign ps2_data_oe = data_oe_q | ((state_q == StInhibit) && (inh_cnt_q == InhLast));

    assign tx.tx_ready = (state_q == StIdle);
    assign tx.tx_busy  = (state_q != StIdle);
    assign tx.tx_done  = done_evt & ~reset;
    assign tx.tx_error = err_evt & ~reset;
    assign tx.tx_nack  = nack_q | (nack_evt & ~reset);

endmodule
